// File: rtl/sprite_arb_pkg.sv
// Shared constants and the wrap-around priority search for the sprite memory arbiter.
package sprite_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 19;
  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned MAX_RD_LAT = 4;
  localparam int unsigned MAX_IDX_W  = $clog2(MAX_REQ);

  // Index of the first set bit of req at or after start, wrapping modulo n.
  // Returns 0 when req is empty; callers qualify with |req.
  function automatic logic [MAX_IDX_W-1:0] first_set_from(input logic [MAX_REQ-1:0] req,
                                                          input int unsigned start,
                                                          input int unsigned n);
    int unsigned j;
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    // Walk from the farthest candidate back to start so the nearest one wins.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < int'(n)) begin
        j = start + k;
        if (j >= n) j = j - n;
        if (req[j]) idx = j[MAX_IDX_W-1:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant and binary index of the winner.
module rr_pick import sprite_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [MAX_REQ-1:0]   w_req_ext;
  logic [MAX_IDX_W-1:0] w_idx;

  // Search upward from the pointer and decode the winner to one-hot.
  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_REQ-1:0] = i_req;
    w_idx                  = first_set_from(w_req_ext, int'(i_ptr), NUM_REQ);
    o_idx                  = w_idx[IDX_W-1:0];
    o_valid                = |i_req;
    o_gnt                  = '0;
    if (o_valid) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among pixel fetchers.
// Optional: ARB_FIXED_PRIO0_EN gives requester 0 (cursor) strict priority.
module sprite_mem_arbiter import sprite_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      pause,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      idle
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("sprite_mem_arbiter: NUM_REQ must be 2..8");
  end
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
    $error("sprite_mem_arbiter: RD_LAT must be 1..4");
  end

  logic [IDX_W-1:0]               r_ptr;
  logic [RD_LAT:0][NUM_REQ-1:0]   r_tag;
  logic [NUM_REQ-1:0]             w_req_rr;
  logic [NUM_REQ-1:0]             w_rr_gnt;
  logic [IDX_W-1:0]               w_rr_idx;
  logic                           w_rr_valid;
  logic [NUM_REQ-1:0]             w_gnt;
  logic [IDX_W-1:0]               w_win;
  logic                           w_adv;
  logic [IDX_W-1:0]               w_ptr_nxt;

`ifdef ARB_FIXED_PRIO0_EN
  // Requester 0 is handled outside the rotation so it never moves the pointer.
  assign w_req_rr = {req[NUM_REQ-1:1], 1'b0};
`else
  assign w_req_rr = req;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (w_req_rr),
    .i_ptr   (r_ptr),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  // Grant selection; reset and pause both suppress any grant in the same cycle.
  always_comb begin
    w_gnt = '0;
    w_win = '0;
    w_adv = 1'b0;
    if (rstn && !pause) begin
`ifdef ARB_FIXED_PRIO0_EN
      if (req[0]) begin
        w_gnt[0] = 1'b1;
      end else
`endif
      if (w_rr_valid) begin
        w_gnt = w_rr_gnt;
        w_win = w_rr_idx;
        w_adv = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // Registered BRAM command, pointer advance and one-hot return-tag pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
      r_ptr    <= '0;
      r_tag    <= '0;
    end else begin
      mem_en <= |w_gnt;
      if (|w_gnt) mem_addr <= req_addr[w_win*ADDR_W +: ADDR_W];
      if (w_adv) r_ptr <= w_ptr_nxt;
      r_tag <= {r_tag[RD_LAT-1:0], w_gnt};
    end
  end

  assign gnt    = w_gnt;
  assign rvalid = r_tag[RD_LAT];
  assign rdata  = mem_rdata;
  assign idle   = ~(|r_tag) & ~(|w_gnt);

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed bench for sprite_mem_arbiter with a BRAM model and a return-order scoreboard.
module tb_sprite_mem_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned RD_LAT  = 2;

  typedef struct packed {
    logic [NUM_REQ-1:0] hot;
    logic [DATA_W-1:0]  data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic                      pause;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      idle;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  logic [ADDR_W-1:0] pipe0, pipe1;

  always #5 clk = ~clk;

  sprite_mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pause     (pause),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .idle      (idle)
  );

  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    return a[11:0] ^ {a[18:12], 5'b0} ^ 12'h5a5;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return ADDR_W'(18000 + 4097 * i);
  endfunction

  // BRAM model: data for the address registered RD_LAT cycles earlier.
  always @(posedge clk) begin
    pipe0 <= mem_addr;
    pipe1 <= pipe0;
  end
  assign mem_rdata = word(pipe1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: grants push the expected return, rvalids pop and compare in order.
  always @(negedge clk) begin
    if (rstn) begin
      if (rvalid != '0) begin
        if (q.size() == 0) begin
          check("rv_unexpected", 32'(rvalid), 32'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rv_order", 32'(rvalid), 32'(e.hot));
          check("rv_rdata", 32'(rdata), 32'(e.data));
        end
      end
      if (gnt != '0) begin
        exp_t e;
        e.hot  = gnt;
        e.data = '0;
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) e.data = word(addr_of(i));
        q.push_back(e);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    q.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && !idle; k++) @(negedge clk);
    check(tag, 32'(idle), 32'(1));
    check({tag, "_sb_empty"}, 32'(q.size()), 32'(0));
  endtask

  initial begin
    logic [1:0] rot[4];
    rstn  = 1'b0;
    pause = 1'b0;
    req   = '1;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_of(i);

    // Reset state, with requests present.
    #12;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_mem_en", 32'(mem_en), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_rvalid", 32'(rvalid), 32'(0));
    check("rst_idle", 32'(idle), 32'(1));
    req = '0;
    @(negedge clk);
    rstn = 1'b1;

    // Single read from requester 0.
    next(); req = 4'b0001;
    smp();  check("t1_gnt", 32'(gnt), 32'(4'b0001));
    check("t1_idle_busy", 32'(idle), 32'(0));
    next(); req = 4'b0000;
    smp();  check("t1_mem_en", 32'(mem_en), 32'(1));
    check("t1_mem_addr", 32'(mem_addr), 32'(18000));
    next(); smp(); check("t1_rv_early", 32'(rvalid), 32'(0));
    next(); smp(); check("t1_rvalid", 32'(rvalid), 32'(4'b0001));
    check("t1_rdata", 32'(rdata), 32'(word(19'd18000)));
    next(); smp(); check("t1_idle", 32'(idle), 32'(1));

    // All four requesting continuously for eight cycles.
    do_reset();
    next(); req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      smp();
      check("t2_gnt", 32'(gnt), 32'(1 << (k % 4)));
      if (k > 0) check("t2_mem_en", 32'(mem_en), 32'(1));
      if (k >= 3) check("t2_rvalid", 32'(rvalid), 32'(1 << ((k - 3) % 4)));
      if (k < 7) next();
    end
    next(); req = '0;
    drain("t2_drain");

    // Pause after two grants.
    do_reset();
    next(); req = 4'b1111;
    smp();  check("t3_gnt0", 32'(gnt), 32'(4'b0001));
    next(); smp(); check("t3_gnt1", 32'(gnt), 32'(4'b0010));
    next(); pause = 1'b1;
    smp();  check("t3_paused_gnt", 32'(gnt), 32'(0));
    check("t3_busy", 32'(idle), 32'(0));
    for (int k = 3; k <= 6; k++) begin
      next(); smp();
      check("t3_paused_gnt", 32'(gnt), 32'(0));
      if (k == 3) check("t3_rv0", 32'(rvalid), 32'(4'b0001));
      if (k == 4) check("t3_rv1", 32'(rvalid), 32'(4'b0010));
      if (k == 4) check("t3_idle_low", 32'(idle), 32'(0));
      if (k == 6) check("t3_idle_high", 32'(idle), 32'(1));
    end
    check("t3_sb_empty", 32'(q.size()), 32'(0));
    next(); pause = 1'b0;
    smp();  check("t3_resume", 32'(gnt), 32'(4'b0100));
    next(); req = '0;
    drain("t3_drain");

    // Asynchronous reset with two reads in flight.
    do_reset();
    next(); req = 4'b1111;
    smp();  check("t4_gnt0", 32'(gnt), 32'(4'b0001));
    next(); smp();
    next(); req = '0;
    #2 rstn = 1'b0;
    #1;
    check("t4_mem_en", 32'(mem_en), 32'(0));
    check("t4_rvalid", 32'(rvalid), 32'(0));
    check("t4_idle", 32'(idle), 32'(1));
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      smp(); check("t4_no_late_rv", 32'(rvalid), 32'(0));
    end
    next(); req = 4'b1010;
    smp();  check("t4_first_gnt", 32'(gnt), 32'(4'b0010));
    next(); req = '0;
    drain("t4_drain");

    // Rotation among 1..3, then requester 0 joins.
    do_reset();
    rot[0] = 2'd1; rot[1] = 2'd2; rot[2] = 2'd3; rot[3] = 2'd1;
    next(); req = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      smp(); check("t5_rot", 32'(gnt), 32'(1 << rot[k]));
      next();
    end
    req = 4'b1111;
`ifdef ARB_FIXED_PRIO0_EN
    smp();  check("t5_prio0_now", 32'(gnt), 32'(4'b0001));
    next(); smp(); check("t5_prio0_hold", 32'(gnt), 32'(4'b0001));
    next(); req = 4'b1110;
    smp();  check("t5_rot_resume", 32'(gnt), 32'(4'b0100));
`else
    smp();  check("t5_rr_join", 32'(gnt), 32'(4'b0100));
    next(); smp(); check("t5_rr_next", 32'(gnt), 32'(4'b1000));
    next(); req = 4'b1110;
    smp();  check("t5_rr_wrap", 32'(gnt), 32'(4'b0010));
`endif
    next(); req = '0;
    drain("t5_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
